// File: rtl/stage_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stage_mem_pkg                                                |
// | Description : Shared pipeline constants: MEM-stage FSM encoding, wait limit |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package stage_mem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  localparam int WAIT_LIMIT_DEFAULT = 255;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stage_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stage_mem_ctrl                                               |
// | Description : MEM-stage request FSM, wait counter and stall generation     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module stage_mem_ctrl
  import stage_mem_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_mem_op,
  input  logic i_mem_ack,
  output logic o_mem_req,
  output logic o_stall,
  output logic o_timeout
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  mem_state_e    r_state;
  mem_state_e    w_state_nxt;
  logic [CW-1:0] r_wait;
  logic [CW-1:0] w_wait_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // The request cycle in IDLE counts as the first stalled cycle, so the
  // timeout fires on the last BUSY cycle and the stall lasts WAIT_LIMIT cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = '0;
    o_timeout   = (r_state == ST_BUSY) && (r_wait == CW'(WAIT_LIMIT - 1));
    o_mem_req   = i_mem_op && !o_timeout;
    o_stall     = o_mem_req && !i_mem_ack;
    case (r_state)
      ST_IDLE: begin
        if (o_mem_req && !i_mem_ack) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if ((o_mem_req && i_mem_ack) || o_timeout || !i_mem_op) w_state_nxt = ST_IDLE;
        else w_wait_nxt = r_wait + 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stage_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stage_mem                                                    |
// | Description : MEM pipeline stage: EX/MEM register, data-memory access, WB  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_ex,
  input  logic [31:0] ans_ex,
  input  logic [31:0] b_ex,
  input  logic [4:0]  rw_ex,
  input  logic        wreg_ex,
  input  logic        m2reg_ex,
  input  logic        wmem_ex,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        wb_we,
  output logic [4:0]  wb_rw,
  output logic [31:0] wb_data,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rw,
  output logic [31:0] fwd_data,
  output logic        mem_err
);

  logic        r_valid;
  logic [31:0] r_ans;
  logic [31:0] r_b;
  logic [4:0]  r_rw;
  logic        r_wreg;
  logic        r_m2reg;
  logic        r_wmem;
  logic        r_wb_we;
  logic [4:0]  r_wb_rw;
  logic [31:0] r_wb_data;
  logic        r_mem_err;

  logic w_is_mem;
  logic w_is_load;
  logic w_aligned;
  logic w_timeout;
  logic w_ack;
  logic w_dest_ok;
  logic w_wb_en;

  // A store flag wins over the load flag when both are set.
  assign w_is_mem  = r_valid && (r_m2reg || r_wmem);
  assign w_is_load = w_is_mem && !r_wmem;
  assign w_aligned = is_aligned(r_ans);
  assign w_ack     = mem_req && mem_ack;
  assign w_dest_ok = r_valid && r_wreg && (r_rw != 5'd0);
  assign w_wb_en   = w_dest_ok && (w_is_load ? w_ack : !w_is_mem);

  stage_mem_ctrl #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_mem_op  (w_is_mem && w_aligned),
    .i_mem_ack (mem_ack),
    .o_mem_req (mem_req),
    .o_stall   (stall),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ans   <= '0;
      r_b     <= '0;
      r_rw    <= '0;
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
      r_wmem  <= 1'b0;
    end else if (!stall) begin
      r_valid <= valid_ex;
      r_ans   <= ans_ex;
      r_b     <= b_ex;
      r_rw    <= rw_ex;
      r_wreg  <= wreg_ex;
      r_m2reg <= m2reg_ex;
      r_wmem  <= wmem_ex;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_we   <= 1'b0;
      r_wb_rw   <= '0;
      r_wb_data <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_wb_we <= w_wb_en;
      if (w_wb_en) begin
        r_wb_rw   <= r_rw;
        r_wb_data <= w_is_load ? mem_rdata : r_ans;
      end
      if ((w_is_mem && !w_aligned) || w_timeout) r_mem_err <= 1'b1;
    end
  end

  assign mem_addr  = {r_ans[31:2], 2'b00};
  assign mem_we    = mem_req && r_wmem;
  assign mem_wdata = r_b;

  assign wb_we   = r_wb_we;
  assign wb_rw   = r_wb_rw;
  assign wb_data = r_wb_data;
  assign mem_err = r_mem_err;

  assign fwd_valid = w_dest_ok && !w_is_load;
  assign fwd_rw    = r_rw;
  assign fwd_data  = r_ans;

endmodule
`default_nettype wire
